// File: rtl/instruction_fetch_unit.sv
// Instruction fetch sequencer: drives a 1-cycle-latency instruction memory
// and hands fetched words to decode through a 2-entry skid FIFO.
module instruction_fetch_unit #(
  parameter int INSTR_WIDTH          = 32,
  parameter int INSTR_MEM_ADDR_WIDTH = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [INSTR_MEM_ADDR_WIDTH-1:0] start_addr,
  input  logic                            abort,
  output logic [INSTR_MEM_ADDR_WIDTH-1:0] address,
  input  logic [INSTR_WIDTH-1:0]          mem_instr,
  input  logic                            mem_instr_valid,
  output logic [INSTR_WIDTH-1:0]          instr_o,
  output logic [INSTR_MEM_ADDR_WIDTH-1:0] pc_o,
  output logic                            instr_o_valid,
  input  logic                            instr_o_ready,
  output logic                            busy,
  output logic                            done,
  output logic                            wrap_err,
  output logic [INSTR_MEM_ADDR_WIDTH:0]   fetch_count
);

  localparam int AW = INSTR_MEM_ADDR_WIDTH;
  localparam int IW = INSTR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e        state_q;
  logic [AW-1:0] pc_q;
  logic          infl_q;
  logic [AW-1:0] infl_addr_q;
  logic          last_q;
  logic          wrapped_q;
  logic          done_q;
  logic          wrap_q;
  logic [AW:0]   cnt_q;

  logic [IW-1:0] data_q [2];
  logic [AW-1:0] fpc_q  [2];
  logic          rd_q;
  logic          wr_q;
  logic [1:0]    occ_q;

  logic          pop;
  logic          ret;
  logic          ret_ok;
  logic          ret_end;
  logic          push;
  logic          at_max;
  logic [2:0]    level;
  logic          issue;
  logic          drain_exit;

  assign pop     = (occ_q != 2'd0) && instr_o_ready;
  assign ret     = infl_q && (state_q == S_RUN);
  assign ret_ok  = ret && mem_instr_valid;
  assign ret_end = ret && !mem_instr_valid;
  assign push    = ret_ok;
  assign at_max  = (pc_q == '1);
  assign level   = 3'(occ_q) + 3'(infl_q);

  // Keep occupancy plus outstanding reads within the FIFO depth.
  assign issue = (state_q == S_RUN) && !last_q && !ret_end &&
                 ((level < 3'd2) || ((level == 3'd2) && pop));

  assign drain_exit = (state_q == S_DRAIN) && !infl_q &&
                      (occ_q == 2'(pop));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      infl_q      <= 1'b0;
      infl_addr_q <= '0;
      last_q      <= 1'b0;
      wrapped_q   <= 1'b0;
      done_q      <= 1'b0;
      wrap_q      <= 1'b0;
      cnt_q       <= '0;
      data_q[0]   <= '0;
      data_q[1]   <= '0;
      fpc_q[0]    <= '0;
      fpc_q[1]    <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      occ_q       <= '0;
    end else begin
      if (pop && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
      if (push) begin
        data_q[wr_q] <= mem_instr;
        fpc_q[wr_q]  <= infl_addr_q;
        wr_q         <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      occ_q  <= occ_q + 2'(push) - 2'(pop);
      infl_q <= issue;
      if (issue) infl_addr_q <= pc_q;
      // The top address is issued once; pc holds there, never showing 0.
      if (issue && !at_max) pc_q <= pc_q + 1'b1;
      if (issue && at_max) last_q <= 1'b1;

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_RUN;
            pc_q      <= start_addr;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
            cnt_q     <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            occ_q     <= '0;
            last_q    <= 1'b0;
            wrapped_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (ret_end) begin
            state_q <= S_DRAIN;
          end else if (ret_ok && last_q) begin
            state_q   <= S_DRAIN;
            wrapped_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_exit) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
            wrap_q  <= wrapped_q;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (abort) begin
        state_q <= S_IDLE;
        infl_q  <= 1'b0;
        rd_q    <= 1'b0;
        wr_q    <= 1'b0;
        occ_q   <= '0;
        last_q  <= 1'b0;
      end
    end
  end

  assign address       = pc_q;
  assign instr_o       = data_q[rd_q];
  assign pc_o          = fpc_q[rd_q];
  assign instr_o_valid = (occ_q != 2'd0);
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign wrap_err      = wrap_q;
  assign fetch_count   = cnt_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus random
// programs and backpressure, checked against a program-order model.
module tb_instruction_fetch_unit;

  localparam int AW = 10;
  localparam int IW = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic          abort;
  logic [AW-1:0] address;
  logic [IW-1:0] mem_instr;
  logic          mem_instr_valid;
  logic [IW-1:0] instr_o;
  logic [AW-1:0] pc_o;
  logic          instr_o_valid;
  logic          instr_o_ready;
  logic          busy;
  logic          done;
  logic          wrap_err;
  logic [AW:0]   fetch_count;

  logic [IW-1:0] mem [DEPTH];

  int checks = 0;
  int failures = 0;

  logic [IW+AW-1:0] exp_q [$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_instr       <= mem[address];
    mem_instr_valid <= (mem[address] != '0);
  end

  instruction_fetch_unit #(
    .INSTR_WIDTH(IW),
    .INSTR_MEM_ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .start_addr(start_addr),
    .abort(abort),
    .address(address),
    .mem_instr(mem_instr),
    .mem_instr_valid(mem_instr_valid),
    .instr_o(instr_o),
    .pc_o(pc_o),
    .instr_o_valid(instr_o_valid),
    .instr_o_ready(instr_o_ready),
    .busy(busy),
    .done(done),
    .wrap_err(wrap_err),
    .fetch_count(fetch_count)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input string pfx);
    check({pfx, "_address"}, address, 0);
    check({pfx, "_instr"}, instr_o, 0);
    check({pfx, "_pc"}, pc_o, 0);
    check({pfx, "_valid"}, instr_o_valid, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_wrap"}, wrap_err, 0);
    check({pfx, "_count"}, fetch_count, 0);
  endtask

  task automatic load_prog();
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    mem[0] = 32'h0100_0000;
    mem[1] = 32'h0100_0104;
    mem[2] = 32'h0300_0800;
    mem[3] = 32'h0400_0810;
    mem[4] = 32'h0000_0000;
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom | 32'h1;
  endtask

  // mode: 0 ready held high, 1 fixed 1,0,0,1,0,1 pattern, 2 random
  task automatic run_prog(input logic [AW-1:0] sa, input int mode,
                          input bit no_zero);
    int a;
    int n_exp;
    bit wexp;
    int k;
    int first;
    int hs;
    bit stall;
    bit zero_seen;
    bit finished;
    logic [IW+AW-1:0] prev;
    bit pat [6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    exp_q.delete();
    a = int'(sa);
    while (a < DEPTH && mem[a] != '0) begin
      exp_q.push_back({mem[a], AW'(a)});
      a++;
    end
    n_exp = exp_q.size();
    wexp = (a == DEPTH);

    start = 1'b1;
    start_addr = sa;
    cyc();
    start = 1'b0;
    k = 1;
    first = -1;
    hs = 0;
    stall = 1'b0;
    zero_seen = 1'b0;
    finished = 1'b0;
    prev = '0;
    while (!finished && k <= 3000) begin
      case (mode)
        0: instr_o_ready = 1'b1;
        1: instr_o_ready = pat[(k - 1) % 6];
        default: instr_o_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (k == 1) check("addr_cycle1", address, sa);
      if (no_zero && busy && address == '0) zero_seen = 1'b1;
      if (stall) begin
        check("stall_valid", instr_o_valid, 1);
        check("stall_hold", {instr_o, pc_o}, prev);
      end
      if (instr_o_valid && first < 0) begin
        first = k;
        check("first_valid_cycle", k, 3);
      end
      if (instr_o_valid && instr_o_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_output", hs + 1, n_exp);
        end else begin
          check("out_word", {instr_o, pc_o}, exp_q.pop_front());
          if (mode == 0) check("out_cycle", k, 3 + hs);
        end
        hs++;
      end
      stall = instr_o_valid && !instr_o_ready;
      prev = {instr_o, pc_o};
      if (done) finished = 1'b1;
      cyc();
      k++;
    end
    check("done_reached", finished, 1);
    check("busy_end", busy, 0);
    check("fetch_count", fetch_count, n_exp);
    check("out_count", hs, n_exp);
    check("wrap_err", wrap_err, wexp);
    if (no_zero) check("addr0_issued", zero_seen, 0);
    instr_o_ready = 1'b0;
  endtask

  initial begin
    int nop;
    int sa;
    rst = 1'b1;
    start = 1'b0;
    start_addr = '0;
    abort = 1'b0;
    instr_o_ready = 1'b0;
    load_prog();
    cyc();
    cyc();
    @(negedge clk);
    reset_checks("reset");
    cyc();
    rst = 1'b0;
    cyc();

    run_prog(10'd0, 0, 1'b0);
    run_prog(10'd0, 1, 1'b0);
    run_prog(10'd2, 0, 1'b0);

    fill_random();
    run_prog(10'd1022, 0, 1'b1);
    run_prog(10'd1000, 2, 1'b1);

    // abort after two handshakes; a start during RUN is ignored
    load_prog();
    instr_o_ready = 1'b1;
    start = 1'b1;
    start_addr = 10'd0;
    cyc();
    start_addr = 10'd3;
    cyc();
    start = 1'b0;
    cyc();
    @(negedge clk);
    check("abort_pc0", {instr_o, pc_o}, {32'h0100_0000, 10'd0});
    cyc();
    abort = 1'b1;
    @(negedge clk);
    check("abort_pc1", {instr_o, pc_o}, {32'h0100_0104, 10'd1});
    cyc();
    abort = 1'b0;
    @(negedge clk);
    check("abort_valid", instr_o_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_count", fetch_count, 2);
    cyc();
    run_prog(10'd0, 0, 1'b0);

    // reset in cycle 4 of a running program
    instr_o_ready = 1'b1;
    start = 1'b1;
    start_addr = 10'd0;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    reset_checks("midrst");
    cyc();
    run_prog(10'd0, 0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      fill_random();
      nop = $urandom_range(0, 200);
      mem[nop] = '0;
      sa = (t == 5) ? nop : $urandom_range(0, nop);
      run_prog(AW'(sa), 2, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
